// File: rtl/mat_pkg.sv
// mat_pkg -- shared types and constants for the matrix row arbiter.
//   DEF_SIZE / DEF_WIDTH : default matrix size and default part width
//   ROW_AW               : row address width for the default size
//   REQ_LU / REQ_TINV    : read requester indices
//   row_t                : one matrix row, element j = {imag,real} at j*2*WIDTH
//   arb_state_e          : arbiter state encoding
package mat_pkg;

  localparam int unsigned DEF_SIZE  = 4;
  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned ROW_W     = DEF_SIZE * 2 * DEF_WIDTH;
  localparam int unsigned ROW_AW    = (DEF_SIZE > 1) ? $clog2(DEF_SIZE) : 1;

  localparam int unsigned REQ_LU   = 0;
  localparam int unsigned REQ_TINV = 1;

  // A stalled read wins over a write once this many write grants in a row
  // have held it off.
  localparam logic [2:0] STREAK_MAX = 3'd4;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin read arbiter with a 1-bit pointer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : the memory slot is free for a read this cycle
//   req_i[1:0]    : pending read requests
//   gnt_o[1:0]    : one-hot read grant (combinational)
//   gnt_idx_o     : index of the granted requester
// After any grant the pointer moves to the requester that was not granted.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic rr_q;

  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = 1'b0;
    if (en_i) begin
      case (req_i)
        2'b01: begin
          gnt_o     = 2'b01;
          gnt_idx_o = 1'b0;
        end
        2'b10: begin
          gnt_o     = 2'b10;
          gnt_idx_o = 1'b1;
        end
        2'b11: begin
          gnt_o     = rr_q ? 2'b10 : 2'b01;
          gnt_idx_o = rr_q;
        end
        default: begin
          gnt_o     = 2'b00;
          gnt_idx_o = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'b0;
    end else if (|gnt_o) begin
      rr_q <= ~gnt_idx_o;
    end
  end

endmodule

// File: rtl/mat_row_arb.sv
// mat_row_arb -- arbitrates one single-port row memory between the LU row
// writer/reader and the triangular-inverse reader.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   rd_req_valid_i/addr: read requests (0 = LU, 1 = TINV)
//   rd_req_ready_o     : read accepted this cycle
//   rd_rsp_valid_o/addr/row : read response, one cycle after the grant
//   wr_valid_i/addr/row, wr_ready_o : LU row write
//   mem_en_o/we_o/addr_o/wdata_o, mem_rdata_i : single-port memory
//   stall_cnt_o        : per-requester saturating stall counts
//                        (only with MAT_ROW_ARB_STATS_EN defined)
// Writes win, except that a read held off by four consecutive writes is
// granted on the next cycle. Grants are combinational; only the response
// tag is registered.
//
// state  | meaning
// IDLE   | no traffic
// ACCESS | requests arriving, accesses being issued
// DRAIN  | last access was a read, its response tail before going idle
module mat_row_arb
  import mat_pkg::*;
#(
  parameter  int unsigned SIZE  = DEF_SIZE,
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned AW    = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int unsigned RW    = SIZE * 2 * WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          rd_req_valid_i,
  input  logic [1:0][AW-1:0]  rd_req_addr_i,
  output logic [1:0]          rd_req_ready_o,
  output logic [1:0]          rd_rsp_valid_o,
  output logic [AW-1:0]       rd_rsp_addr_o,
  output logic [RW-1:0]       rd_rsp_row_o,
  input  logic                wr_valid_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [RW-1:0]       wr_row_i,
  output logic                wr_ready_o,
`ifdef MAT_ROW_ARB_STATS_EN
  output logic [1:0][15:0]    stall_cnt_o,
`endif
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [AW-1:0]       mem_addr_o,
  output logic [RW-1:0]       mem_wdata_o,
  input  logic [RW-1:0]       mem_rdata_i
);

  arb_state_e    state_q;
  logic [2:0]    wr_streak_q;
  logic [1:0]    rsp_vld_q;
  logic [AW-1:0] rsp_addr_q;

  logic [1:0]    rd_pend;
  logic          wr_pend;
  logic          any_valid;
  logic          starve;
  logic          wr_gnt;
  logic [1:0]    rd_gnt;
  logic          rd_idx;

  // Requests are masked while reset is held so no handshake or memory
  // strobe can appear during reset.
  assign rd_pend   = rst_ni ? rd_req_valid_i : 2'b00;
  assign wr_pend   = rst_ni & wr_valid_i;
  assign any_valid = wr_pend | (|rd_pend);

  assign starve = (wr_streak_q == STREAK_MAX) && (|rd_pend);
  assign wr_gnt = wr_pend && !starve;

  rr_arb2 u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (~wr_gnt),
    .req_i     (rd_pend),
    .gnt_o     (rd_gnt),
    .gnt_idx_o (rd_idx)
  );

  assign wr_ready_o     = wr_gnt;
  assign rd_req_ready_o = rd_gnt;
  assign mem_en_o       = wr_gnt | (|rd_gnt);
  assign mem_we_o       = wr_gnt;
  assign mem_addr_o     = wr_gnt      ? wr_addr_i :
                          (|rd_gnt)   ? rd_req_addr_i[rd_idx] : '0;
  assign mem_wdata_o    = wr_gnt ? wr_row_i : '0;

  assign rd_rsp_valid_o = rsp_vld_q;
  assign rd_rsp_addr_o  = rsp_addr_q;
  assign rd_rsp_row_o   = (|rsp_vld_q) ? mem_rdata_i : '0;

  // Counts write grants that held off a pending read; never exceeds
  // STREAK_MAX because at that value the read takes the slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_streak_q <= 3'd0;
    end else if (wr_gnt && (|rd_pend)) begin
      wr_streak_q <= wr_streak_q + 3'd1;
    end else begin
      wr_streak_q <= 3'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rsp_vld_q  <= 2'b00;
      rsp_addr_q <= '0;
    end else begin
      rsp_vld_q <= rd_gnt;
      if (|rd_gnt) begin
        rsp_addr_q <= rd_req_addr_i[rd_idx];
      end
      case (state_q)
        IDLE: begin
          if (any_valid) state_q <= ACCESS;
        end
        ACCESS: begin
          if (any_valid)        state_q <= ACCESS;
          else if (|rsp_vld_q)  state_q <= DRAIN;
          else                  state_q <= IDLE;
        end
        DRAIN: begin
          state_q <= any_valid ? ACCESS : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MAT_ROW_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rd_pend[i] && !rd_gnt[i] && (stall_cnt_o[i] != 16'hFFFF)) begin
          stall_cnt_o[i] <= stall_cnt_o[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule
